// File: rtl/bus_master_port_pkg.sv
// Shared definitions for the serial bus master port.
// State encodings, bus mode constants and default ack timeout.
package bus_master_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK   = 3'd3,
        ST_WDATA = 3'd4,
        ST_WEND  = 3'd5,
        ST_RDATA = 3'd6
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEF_ACK_TIMEOUT = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_serdes_bit.sv
// LSB-first shift register with bit counter and last-bit flag.
// Ports: clr/load/ld_data, shift/sin, len; sout, nxt, done.
module bus_serdes_bit
    import bus_master_port_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  ld_data,
    input  logic          shift,
    input  logic          sin,
    input  logic [CW-1:0] len,
    output logic          sout,
    output logic [W-1:0]  nxt,
    output logic          done
);

    logic [W-1:0]  q;
    logic [CW-1:0] cnt;

    assign sout = q[0];
    assign nxt  = {sin, q[W-1:1]};
    // High during the shift of the final bit of a len-bit word.
    assign done = shift && (cnt == len - 1'b1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            if (load)
                q <= ld_data;
            else if (shift)
                q <= nxt;

            if (load || clr)
                cnt <= '0;
            else if (shift)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Device-side master port: parallel request -> serial bus transaction.
// Ports: d_* device side, m_* serial bus side; clk, rstn (sync, low).
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  d_valid,
    input  logic                  d_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  m_breq,
    input  logic                  m_bgrant,
    output logic                  m_mode,
    output logic                  m_mvalid,
    output logic                  m_wdata,
    input  logic                  m_ack,
    input  logic                  m_svalid,
    input  logic                  m_rdata,
    input  logic                  m_sready
);

    localparam int TXW = max2(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW  = $clog2(TXW + 1);
    localparam int TOW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0]  A_LEN   = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0]  D_LEN   = CW'(DATA_WIDTH);
    localparam logic [TOW-1:0] TO_LAST = TOW'(ACK_TIMEOUT - 1);

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] wdata_q;
    logic [TOW-1:0]        to_q;

    logic           accept;
    logic           err_set;
    logic           rd_load;
    logic           st_chg;

    logic           tx_load;
    logic [TXW-1:0] tx_ld;
    logic           tx_shift;
    logic [CW-1:0]  tx_len;
    logic           tx_sout;
    logic [TXW-1:0] tx_nxt_unused;
    logic           tx_done;

    logic                  rx_shift;
    logic                  rx_sout_unused;
    logic [DATA_WIDTH-1:0] rx_nxt;
    logic                  rx_done;

    always_comb begin
        state_d = state_q;
        tx_load = 1'b0;
        tx_ld   = TXW'(d_addr);
        accept  = 1'b0;
        err_set = 1'b0;
        rd_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (d_valid) begin
                    state_d = ST_REQ;
                    tx_load = 1'b1;
                    accept  = 1'b1;
                end
            end
            ST_REQ: begin
                if (m_bgrant)
                    state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (tx_done)
                    state_d = ST_ACK;
            end
            ST_ACK: begin
                if (m_ack) begin
                    if (m_mode == MODE_WRITE) begin
                        state_d = ST_WDATA;
                        tx_load = 1'b1;
                        tx_ld   = TXW'(wdata_q);
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end
            end
            ST_WDATA: begin
                if (tx_done)
                    state_d = ST_WEND;
            end
            ST_WEND: begin
                if (m_sready)
                    state_d = ST_IDLE;
            end
            ST_RDATA: begin
                if (rx_done) begin
                    state_d = ST_IDLE;
                    rd_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign st_chg   = (state_d != state_q);
    assign tx_shift = (state_q == ST_ADDR) ||
                      (state_q == ST_WDATA);
    assign tx_len   = (state_q == ST_ADDR) ? A_LEN : D_LEN;
    assign rx_shift = (state_q == ST_RDATA) && m_svalid;

    // TX register holds the address, then is reloaded with write data on ack;
    // its LSB is the registered serial output.
    assign m_wdata = tx_sout;

    bus_serdes_bit #(
        .W  (TXW),
        .CW (CW)
    ) u_tx (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (st_chg),
        .load    (tx_load),
        .ld_data (tx_ld),
        .shift   (tx_shift),
        .sin     (1'b0),
        .len     (tx_len),
        .sout    (tx_sout),
        .nxt     (tx_nxt_unused),
        .done    (tx_done)
    );

    bus_serdes_bit #(
        .W  (DATA_WIDTH),
        .CW (CW)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (st_chg),
        .load    (1'b0),
        .ld_data ('0),
        .shift   (rx_shift),
        .sin     (m_rdata),
        .len     (D_LEN),
        .sout    (rx_sout_unused),
        .nxt     (rx_nxt),
        .done    (rx_done)
    );

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            to_q     <= '0;
            wdata_q  <= '0;
            d_ready  <= 1'b1;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            m_breq   <= 1'b0;
            m_mode   <= 1'b0;
            m_mvalid <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_q     <= (state_q == ST_ACK && !st_chg) ? to_q + 1'b1 : '0;
            d_ready  <= (state_d == ST_IDLE);
            m_breq   <= (state_d != ST_IDLE);
            m_mvalid <= (state_d == ST_ADDR) || (state_d == ST_WDATA);
            if (accept) begin
                m_mode  <= d_mode;
                wdata_q <= d_wdata;
                d_err   <= 1'b0;
            end
            if (err_set)
                d_err <= 1'b1;
            if (rd_load)
                d_rdata <= rx_nxt;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: plays arbiter and slave.
// Checks serial bit streams, latencies, timeout, reset and holds.
module tb_bus_master_port;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          d_valid;
    logic          d_mode;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          m_breq;
    logic          m_bgrant;
    logic          m_mode;
    logic          m_mvalid;
    logic          m_wdata;
    logic          m_ack;
    logic          m_svalid;
    logic          m_rdata;
    logic          m_sready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .d_valid  (d_valid),
        .d_mode   (d_mode),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_breq   (m_breq),
        .m_bgrant (m_bgrant),
        .m_mode   (m_mode),
        .m_mvalid (m_mvalid),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_svalid (m_svalid),
        .m_rdata  (m_rdata),
        .m_sready (m_sready)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction. Returns lat = cycle index of d_ready=1, where
    // the cycle right after the grant-sampling edge is cycle 1.
    task automatic xfer(input logic mode, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int gdly,
                        input bit ack_ok, input logic [DW-1:0] rd,
                        input bit gap, input logic [DW-1:0] prev,
                        output int lat);
        int k;
        bit ph;
        d_valid  = 1'b1;
        d_mode   = mode;
        d_addr   = addr;
        d_wdata  = wd;
        m_bgrant = 1'b0;
        m_ack    = 1'b0;
        m_sready = 1'b1;
        m_svalid = 1'b0;
        tick();
        d_valid = 1'b0;
        check("acc_ready", d_ready, 0);
        check("acc_breq", m_breq, 1);
        check("acc_err", d_err, 0);
        for (int g = 0; g < gdly; g++) begin
            check("wait_mvalid", m_mvalid, 0);
            check("wait_breq", m_breq, 1);
            d_valid = (g % 2 == 0);
            d_mode  = ~mode;
            d_addr  = ~addr;
            d_wdata = ~wd;
            tick();
        end
        d_valid  = 1'b0;
        m_bgrant = 1'b1;
        tick();
        m_bgrant = 1'b0;
        lat = 1;
        for (int b = 0; b < AW; b++) begin
            check($sformatf("addr_v%0d", b), m_mvalid, 1);
            check($sformatf("addr_b%0d", b), m_wdata, addr[b]);
            check("addr_mode", m_mode, mode);
            tick();
            lat++;
        end
        check("ack_mvalid", m_mvalid, 0);
        if (!ack_ok) begin
            for (int t = 0; t < TO; t++) begin
                check("to_busy", d_ready, 0);
                tick();
                lat++;
            end
            check("to_ready", d_ready, 1);
            check("to_err", d_err, 1);
            check("to_breq", m_breq, 0);
            check("to_rdata", d_rdata, prev);
            return;
        end
        m_ack = 1'b1;
        tick();
        lat++;
        m_ack = 1'b0;
        if (mode) begin
            for (int b = 0; b < DW; b++) begin
                check($sformatf("wd_v%0d", b), m_mvalid, 1);
                check($sformatf("wd_b%0d", b), m_wdata, wd[b]);
                tick();
                lat++;
            end
            check("wend_busy", d_ready, 0);
            check("wend_mvalid", m_mvalid, 0);
            tick();
            lat++;
            check("wr_ready", d_ready, 1);
            check("wr_breq", m_breq, 0);
            check("wr_rdata_hold", d_rdata, prev);
        end else begin
            k  = 0;
            ph = 1'b0;
            for (int i = 0; i < 40 && k < DW; i++) begin
                if (gap && ph) begin
                    m_svalid = 1'b0;
                end else begin
                    m_svalid = 1'b1;
                    m_rdata  = rd[k];
                    if (k == DW - 1) begin
                        check("rd_early", d_rdata, prev);
                        check("rd_busy", d_ready, 0);
                    end
                    k++;
                end
                ph = ~ph;
                tick();
                lat++;
            end
            m_svalid = 1'b0;
            check("rd_bits", k, DW);
            check("rd_ready", d_ready, 1);
            check("rd_data", d_rdata, rd);
            check("rd_breq", m_breq, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rstn     = 1'b0;
        d_valid  = 1'b0;
        d_mode   = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        m_bgrant = 1'b0;
        m_ack    = 1'b0;
        m_svalid = 1'b0;
        m_rdata  = 1'b0;
        m_sready = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
        check("rst_ready", d_ready, 1);
        check("rst_rdata", d_rdata, 0);
        check("rst_err", d_err, 0);
        check("rst_breq", m_breq, 0);
        check("rst_mode", m_mode, 0);
        check("rst_mvalid", m_mvalid, 0);
        check("rst_wdata", m_wdata, 0);
        tick();

        // Write: 1 + 16 + 1 + 8 + 1 = 27 cycles grant-to-ready.
        xfer(1'b1, 16'h8001, 8'hA5, 0, 1'b1, 8'h00, 1'b0, 8'h00, lat);
        check("wr_latency", lat, 27);

        // Read with every-other-cycle stalls.
        xfer(1'b0, 16'h4001, 8'h00, 0, 1'b1, 8'h3C, 1'b1, 8'h00, lat);

        // Delayed grant with ignored d_valid pulses; rdata holds.
        xfer(1'b1, 16'h1234, 8'h77, 5, 1'b1, 8'h00, 1'b0, 8'h3C, lat);

        // No ack: timeout, error, rdata unchanged.
        xfer(1'b0, 16'h0F0F, 8'h00, 0, 1'b0, 8'h00, 1'b0, 8'h3C, lat);
        check("to_latency", lat, 1 + AW + TO);

        // Reset mid-address at bit 7.
        d_valid = 1'b1;
        d_mode  = 1'b1;
        d_addr  = 16'h00FF;
        d_wdata = 8'hC3;
        tick();
        d_valid  = 1'b0;
        m_bgrant = 1'b1;
        tick();
        m_bgrant = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_bit7", m_wdata, 1);
        check("mid_mvalid", m_mvalid, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mrst_breq", m_breq, 0);
        check("mrst_mvalid", m_mvalid, 0);
        check("mrst_ready", d_ready, 1);
        check("mrst_err", d_err, 0);
        check("mrst_rdata", d_rdata, 0);
        tick();
        check("mrst_idle", m_breq, 0);

        // Back-to-back write then read of the same address.
        xfer(1'b1, 16'h2468, 8'h5A, 0, 1'b1, 8'h00, 1'b0, 8'h00, lat);
        check("b2b_wr_lat", lat, 27);
        xfer(1'b0, 16'h2468, 8'h00, 0, 1'b1, 8'h5A, 1'b0, 8'h00, lat);
        check("b2b_rd_lat", lat, 1 + AW + 1 + DW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
